inner_job_engine: RTL and testbench

//   Responder side of the inner_start/done job handshake. Idle until a one-cycle

---
 rtl/inner_job_engine_if.sv | 30 +++
 rtl/inner_job_engine.sv | 115 +++++++++++
 tb/tb_inner_job_engine.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/inner_job_engine_if.sv
// Job handshake bundle between the top-level controller and inner_job_engine.
// Holds the start/done job handshake, job parameters, and both data streams.
interface inner_job_engine_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int LEN_W  = 4,
  parameter int NOUT_W = 4
);
  logic              inner_start;
  logic [LEN_W-1:0]  len;
  logic [NOUT_W-1:0] n_out;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [ACC_W-1:0]  out_data;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    output inner_start, len, n_out, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  inner_start, len, n_out, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/inner_job_engine.sv
// inner_job_engine: responder side of the inner_start/done job handshake.
// A job produces n_out results, each the unsigned sum of len streamed words,
// and ends with a one-cycle done pulse.
// Build option: define ACC_SAT_EN to saturate the accumulator at 2^ACC_W-1
// instead of wrapping modulo 2^ACC_W.
module inner_job_engine #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int LEN_W  = 4,
  parameter int NOUT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  inner_job_engine_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, OUT, DONE} state_t;

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc;
  logic [LEN_W-1:0]  word_cnt, len_q;
  logic [NOUT_W-1:0] out_cnt, nout_q;
  logic              in_fire, out_fire, last_word, last_out;
  logic              in_ready_c, out_valid_c, busy_c, done_c;

  // Unsigned accumulate; one extra bit catches the carry out of ACC_W.
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [DATA_W-1:0] d);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + {{(ACC_W + 1 - DATA_W){1'b0}}, d};
`ifdef ACC_SAT_EN
    if (sum[ACC_W]) return {ACC_W{1'b1}};
    return sum[ACC_W-1:0];
`else
    return sum[ACC_W-1:0];
`endif
  endfunction

  // A latched count of 0 means the full 2^W, so "last" is count == latched-1 mod 2^W.
  assign last_word = (word_cnt == len_q - LEN_W'(1));
  assign last_out  = (out_cnt == nout_q - NOUT_W'(1));
  assign in_fire   = (state == RUN) && bus.in_valid;
  assign out_fire  = (state == OUT) && bus.out_ready;

  // State register; reset aborts any job without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b1;
    done_c      = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.inner_start) state_nxt = RUN;
      end
      RUN: begin
        in_ready_c = 1'b1;
        if (in_fire && last_word) state_nxt = OUT;
      end
      OUT: begin
        out_valid_c = 1'b1;
        if (out_fire) state_nxt = last_out ? DONE : RUN;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job parameters, counters and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      word_cnt <= '0;
      out_cnt  <= '0;
      len_q    <= '0;
      nout_q   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.inner_start) begin
          len_q    <= bus.len;
          nout_q   <= bus.n_out;
          acc      <= '0;
          word_cnt <= '0;
          out_cnt  <= '0;
        end
        RUN: if (in_fire) begin
          acc      <= acc_add(acc, bus.in_data);
          word_cnt <= last_word ? '0 : word_cnt + LEN_W'(1);
        end
        OUT: if (out_fire) begin
          out_cnt <= out_cnt + NOUT_W'(1);
          if (!last_out) acc <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_valid_c ? acc : '0;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;

endmodule

// File: tb/tb_inner_job_engine.sv
// Directed bench for inner_job_engine: inputs change on the falling edge and
// outputs are checked there, half a cycle away from the rising edge.
module tb_inner_job_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec  = 0;
  int   miss = 0;
  int   done_seen = 0;
  int   done_mark;

  always #5 clk = ~clk;

  inner_job_engine_if #(.DATA_W(8), .ACC_W(20), .LEN_W(4), .NOUT_W(4)) bus ();
  inner_job_engine_if #(.DATA_W(8), .ACC_W(8),  .LEN_W(4), .NOUT_W(4)) bus8 ();

  inner_job_engine #(.DATA_W(8), .ACC_W(20), .LEN_W(4), .NOUT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  inner_job_engine #(.DATA_W(8), .ACC_W(8), .LEN_W(4), .NOUT_W(4)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );

  always @(negedge clk) if (bus.done) done_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    if (obs !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [3:0] l, input logic [3:0] n);
    bus.inner_start = 1'b1;
    bus.len         = l;
    bus.n_out       = n;
    @(negedge clk);
    bus.inner_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_outputs(input string tag);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_in_ready"},  bus.in_ready,  0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"},  bus.out_data,  0);
    check({tag, "_done"},      bus.done,      0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.inner_start = 0; bus.len = 0; bus.n_out = 0;
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    bus8.inner_start = 0; bus8.len = 0; bus8.n_out = 0;
    bus8.in_valid = 0; bus8.in_data = 0; bus8.out_ready = 0;

    // reset state
    @(negedge clk); @(negedge clk);
    idle_outputs("reset");
    rst = 1'b0;

    // len=3, n_out=1, words 1,2,3
    start_job(4'd3, 4'd1);
    check("t2_in_ready", bus.in_ready, 1);
    check("t2_busy", bus.busy, 1);
    send(8'd1); send(8'd2); send(8'd3);
    check("t2_out_valid", bus.out_valid, 1);
    check("t2_out_data", bus.out_data, 6);
    check("t2_in_ready_out", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t2_done", bus.done, 1);
    check("t2_out_valid_done", bus.out_valid, 0);
    @(negedge clk);
    check("t2_done_low", bus.done, 0);
    check("t2_busy_low", bus.busy, 0);

    // len=2, n_out=2, words 5,7,10,20
    done_mark = done_seen;
    start_job(4'd2, 4'd2);
    send(8'd5); send(8'd7);
    check("t3_r0_valid", bus.out_valid, 1);
    check("t3_r0_data", bus.out_data, 12);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t3_back_run", bus.in_ready, 1);
    check("t3_no_early_done", bus.done, 0);
    send(8'd10); send(8'd20);
    check("t3_r1_valid", bus.out_valid, 1);
    check("t3_r1_data", bus.out_data, 30);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t3_done", bus.done, 1);
    @(negedge clk); @(negedge clk);
    check("t3_busy_low", bus.busy, 0);
    check("t3_done_count", done_seen - done_mark, 1);

    // backpressure in OUT, words offered are not consumed
    start_job(4'd2, 4'd1);
    send(8'd3); send(8'd4);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'd99;
      check("t4_hold_valid", bus.out_valid, 1);
      check("t4_hold_data", bus.out_data, 7);
      check("t4_hold_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    check("t4_still_data", bus.out_data, 7);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t4_done", bus.done, 1);
    @(negedge clk);

    // in_valid gaps in RUN stall the count and leave acc alone
    start_job(4'd3, 4'd1);
    send(8'd1);
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'd50;
      @(negedge clk);
      check("t4_gap_in_ready", bus.in_ready, 1);
      check("t4_gap_out_valid", bus.out_valid, 0);
    end
    send(8'd2);
    @(negedge clk); @(negedge clk);
    check("t4_gap2_in_ready", bus.in_ready, 1);
    send(8'd4);
    check("t4_gap_result", bus.out_data, 7);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t4_gap_done", bus.done, 1);
    @(negedge clk);

    // inner_start during RUN is ignored
    start_job(4'd2, 4'd1);
    send(8'd8);
    bus.inner_start = 1'b1; bus.len = 4'd5; bus.n_out = 4'd3;
    @(negedge clk);
    bus.inner_start = 1'b0;
    send(8'd9);
    check("t5_ign_valid", bus.out_valid, 1);
    check("t5_ign_data", bus.out_data, 17);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t5_ign_done", bus.done, 1);
    // inner_start alongside the done pulse is also ignored
    bus.inner_start = 1'b1; bus.len = 4'd1; bus.n_out = 4'd1;
    @(negedge clk);
    bus.inner_start = 1'b0;
    check("t5_start_at_done", bus.busy, 0);
    @(negedge clk);
    check("t5_still_idle", bus.busy, 0);

    // len=0 means 16 words
    start_job(4'd0, 4'd1);
    for (int i = 1; i <= 15; i++) send(i[7:0]);
    check("t5_len0_not_yet", bus.out_valid, 0);
    send(8'd16);
    check("t5_len0_valid", bus.out_valid, 1);
    check("t5_len0_sum", bus.out_data, 136);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(negedge clk);

    // reset during OUT aborts without done; next job starts from zero
    done_mark = done_seen;
    start_job(4'd1, 4'd2);
    send(8'd100);
    check("t5_rst_pre", bus.out_data, 100);
    #2 rst = 1'b1;
    #1 idle_outputs("t5_rst_async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("t5_rst_no_done", done_seen - done_mark, 0);
    start_job(4'd1, 4'd1);
    send(8'd5);
    check("t5_rst_fresh", bus.out_data, 5);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(negedge clk);

    // ACC_W=8: 200+100 wraps to 44, or saturates to 255
    bus8.inner_start = 1'b1; bus8.len = 4'd2; bus8.n_out = 4'd1;
    @(negedge clk);
    bus8.inner_start = 1'b0;
    bus8.in_valid = 1'b1; bus8.in_data = 8'd200;
    @(negedge clk);
    bus8.in_data = 8'd100;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    check("t6_valid", bus8.out_valid, 1);
`ifdef ACC_SAT_EN
    check("t6_sat", bus8.out_data, 255);
`else
    check("t6_wrap", bus8.out_data, 44);
`endif
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
    check("t6_done", bus8.done, 1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
